// File: rtl/alu_sequencer.sv
// Round-robin front end for a shared combinational ALU: registers the granted
// operands, waits a per-op settle latency, then returns the sampled result.
module alu_sequencer #(
    parameter int         ADD_LAT = 1,
    parameter int         MUL_LAT = 3,
    parameter logic [3:0] OP_ADD  = 4'b1010,
    parameter logic [3:0] OP_SUB  = 4'b1011,
    parameter logic [3:0] OP_MUL  = 4'b1100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_z,
    output logic        rsp_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_c,
    input  logic        alu_z,
    output logic        busy
);

    localparam int MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] ADD_CNT = CW'(ADD_LAT - 1);
    localparam logic [CW-1:0] MUL_CNT = CW'(MUL_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last;
    logic          pend_id;
    logic          gnt_any;
    logic          gnt_id;
    logic [3:0]    sel_op;
    logic [31:0]   sel_a;
    logic [31:0]   sel_b;
    logic          legal;

    // last holds the most recent winner; a tie goes to the other requester
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (state == IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt_any = 1'b1;
                gnt_id  = ~last;
            end else if (req0_valid) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b0;
            end else if (req1_valid) begin
                gnt_any = 1'b1;
                gnt_id  = 1'b1;
            end
        end
    end

    assign req0_ready = gnt_any & ~gnt_id;
    assign req1_ready = gnt_any & gnt_id;
    assign busy       = (state != IDLE);

    assign sel_op = gnt_id ? req1_op : req0_op;
    assign sel_a  = gnt_id ? req1_a : req0_a;
    assign sel_b  = gnt_id ? req1_b : req0_b;

    assign legal = (alu_op == OP_ADD) || (alu_op == OP_SUB) ||
                   (alu_op == OP_MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= 1'b1;
            pend_id   <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_z     <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_any) begin
                        alu_a   <= sel_a;
                        alu_b   <= sel_b;
                        alu_op  <= sel_op;
                        pend_id <= gnt_id;
                        last    <= gnt_id;
                        cnt     <= (sel_op == OP_MUL) ? MUL_CNT : ADD_CNT;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == '0) begin
                        rsp_data  <= alu_c;
                        rsp_z     <= alu_z;
                        rsp_err   <= ~legal;
                        rsp_id    <= pend_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU on the far side.
module tb_alu_sequencer;

    localparam logic [3:0] ADD = 4'b1010;
    localparam logic [3:0] SUB = 4'b1011;
    localparam logic [3:0] MUL = 4'b1100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [3:0]  req0_op = '0;
    logic [31:0] req0_a = '0;
    logic [31:0] req0_b = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [3:0]  req1_op = '0;
    logic [31:0] req1_a = '0;
    logic [31:0] req1_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_z;
    logic        rsp_err;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_c;
    logic        alu_z;
    logic        busy;
    logic        z_hold = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    alu_sequencer dut (
        .clk(clk),
        .rst_n(rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_op(req0_op),
        .req0_a(req0_a),
        .req0_b(req0_b),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_op(req1_op),
        .req1_a(req1_a),
        .req1_b(req1_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .rsp_z(rsp_z),
        .rsp_err(rsp_err),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_op(alu_op),
        .alu_c(alu_c),
        .alu_z(alu_z),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // ALU stand-in; unknown opcodes shift A left and keep the old Z
    always_comb begin
        alu_c = '0;
        alu_z = z_hold;
        case (alu_op)
            ADD: begin
                alu_c = alu_a + alu_b;
                alu_z = 1'b0;
            end
            SUB: begin
                alu_c = alu_a - alu_b;
                alu_z = (alu_c == '0);
            end
            MUL: begin
                alu_c = alu_a * alu_b;
                alu_z = (alu_c == '0);
            end
            default: alu_c = alu_a << 1;
        endcase
    end

    always_ff @(posedge clk) z_hold <= alu_z;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic id, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req0_valid = !id;
        req1_valid = id;
        if (id) begin
            req1_op = op;
            req1_a  = a;
            req1_b  = b;
        end else begin
            req0_op = op;
            req0_a  = a;
            req0_b  = b;
        end
        #1;
        chk("rdy_gnt", id ? req1_ready : req0_ready, 1);
        chk("rdy_other", id ? req0_ready : req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("busy_acc", busy, 1);
        chk("alu_op", alu_op, op);
        chk("alu_a", alu_a, a);
        chk("alu_b", alu_b, b);
    endtask

    task automatic wait_rsp(input int lat, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            chk("hold_op", alu_op, op);
            chk("hold_a", alu_a, a);
            chk("hold_b", alu_b, b);
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("latency", n, lat);
    endtask

    task automatic take();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_clr", rsp_valid, 0);
        chk("idle", busy, 0);
    endtask

    initial begin
        int g;
        int cyc;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_rdy0", req0_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD alone
        issue(0, ADD, 32'd5, 32'd7);
        wait_rsp(1, ADD, 32'd5, 32'd7);
        chk("add_data", rsp_data, 32'd12);
        chk("add_z", rsp_z, 0);
        chk("add_id", rsp_id, 0);
        chk("add_err", rsp_err, 0);
        chk("add_busy", busy, 1);
        take();

        // SUB to zero
        issue(1, SUB, 32'd9, 32'd9);
        wait_rsp(1, SUB, 32'd9, 32'd9);
        chk("sub_data", rsp_data, 0);
        chk("sub_z", rsp_z, 1);
        chk("sub_id", rsp_id, 1);
        take();

        // contention: alternating grants starting with req0
        req0_op = ADD;
        req0_a = 32'd1;
        req0_b = 32'd1;
        req1_op = ADD;
        req1_a = 32'd2;
        req1_b = 32'd2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rsp_ready = 1'b1;
        g = 0;
        cyc = 0;
        while (g < 4 && cyc < 100) begin
            #1;
            chk("overlap", req0_ready & req1_ready, 0);
            if (req0_ready | req1_ready) begin
                chk("grant", req1_ready, g & 1);
                g++;
            end
            @(negedge clk);
            cyc++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("grants", g, 4);
        cyc = 0;
        while (busy && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain", busy, 0);
        rsp_ready = 1'b0;

        // MUL wrap with 3-cycle latency
        issue(0, MUL, 32'h0001_0000, 32'h0001_0000);
        wait_rsp(3, MUL, 32'h0001_0000, 32'h0001_0000);
        chk("mul_data", rsp_data, 0);
        chk("mul_z", rsp_z, 1);
        take();

        // backpressure holds the response and blocks new accepts
        issue(1, ADD, 32'h7fff_ffff, 32'd1);
        wait_rsp(1, ADD, 32'h7fff_ffff, 32'd1);
        req0_op = ADD;
        req0_a = 32'd1;
        req0_b = 32'd2;
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 32'h8000_0000);
            chk("bp_z", rsp_z, 0);
            chk("bp_id", rsp_id, 1);
            chk("bp_rdy0", req0_ready, 0);
            chk("bp_rdy1", req1_ready, 0);
            @(negedge clk);
        end
        take();
        #1 chk("resume", req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("res_a", alu_a, 32'd1);
        wait_rsp(1, ADD, 32'd1, 32'd2);
        chk("res_data", rsp_data, 32'd3);
        chk("res_id", rsp_id, 0);
        take();

        // reset in the middle of a MUL
        issue(0, MUL, 32'd2, 32'd3);
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_valid", rsp_valid, 0);
        chk("mr_op", alu_op, 0);
        chk("mr_a", alu_a, 0);
        chk("mr_b", alu_b, 0);
        chk("mr_data", rsp_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst", rsp_valid, 0);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("tie_rdy0", req0_ready, 1);
        chk("tie_rdy1", req1_ready, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // illegal opcode
        issue(0, 4'b0001, 32'd3, 32'd0);
        wait_rsp(1, 4'b0001, 32'd3, 32'd0);
        chk("ill_err", rsp_err, 1);
        chk("ill_data", rsp_data, 32'd6);
        chk("ill_id", rsp_id, 0);
        take();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
